aes_cbc_decrypt_iter: RTL and testbench

Iterative, handshake-driven AES-128 decryption core, the successor to the fully unrolled decryption top. It runs one inverse round per clock over a stored round-key file, adds valid/ready flow control on input and output, and has an optional CBC chaining mode selected by parameter. It sits between the CRC-checked receive buffer and the plaintext consumer.

---
 rtl/aes_cbc_decrypt_iter.sv | 342 ++++++++++++++++++++++++++++++++++
 tb/tb_aes_cbc_decrypt_iter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cbc_decrypt_iter.sv
`default_nettype none
// ============================================================================
// Module      : aes_cbc_decrypt_iter (plus aes_gf_inv, aes_sbox, aes_inv_sbox)
// Description : Iterative AES-128 decryption core with valid/ready flow
//               control. It runs one inverse round per clock from a stored
//               round-key file and has optional CBC chaining.
//               The key schedule is expanded forward, one round key per
//               clock, into an 11x128 register file after a key_load strobe.
//               A block is accepted in READY, takes 10 inverse rounds, and is
//               then held in DONE until the consumer takes it.
// Ports       : clk, rst (async, active-high)
//               key_load/key          -> start key expansion
//               key_ready             <- round-key file valid
//               iv_load/iv            -> load chaining value (CBC only)
//               in_valid/in_ready     <> ciphertext handshake (cipher_text)
//               out_valid/out_ready   <> plaintext handshake (plain_text)
//               busy                  <- expanding, decrypting or holding
// Revision    : 1.0  initial release
// ============================================================================

// GF(2^8) multiplicative inverse (0 maps to 0), computed as x^254.
module aes_gf_inv (
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] x;
      acc = 8'h00;
      x   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   // Square-and-multiply: after step i, p = x^(2^(i+1)) and r accumulates
   // x^(2+4+...+128) = x^254.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] p;
      logic [7:0] r;
      p = x;
      r = 8'h01;
      for (int i = 0; i < 7; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   assign out_byte = gf_inv(in_byte);
endmodule

// Forward S-box: inverse followed by the affine transform.
module aes_sbox (
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);
   logic [7:0] w_inv;

   aes_gf_inv u_inv (.in_byte(in_byte), .out_byte(w_inv));

   assign out_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                   ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
endmodule

// Inverse S-box: inverse affine transform followed by the inverse.
module aes_inv_sbox (
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);
   logic [7:0] w_aff;

   assign w_aff = {in_byte[6:0], in_byte[7]} ^ {in_byte[4:0], in_byte[7:5]}
                ^ {in_byte[1:0], in_byte[7:2]} ^ 8'h05;

   aes_gf_inv u_inv (.in_byte(w_aff), .out_byte(out_byte));
endmodule

module aes_cbc_decrypt_iter #(
   parameter int CBC_EN = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         key_load,
   input  logic [127:0] key,
   output logic         key_ready,
   input  logic         iv_load,
   input  logic [127:0] iv,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] cipher_text,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] plain_text,
   output logic         busy
);
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_KEXP  = 3'd1,
      S_READY = 3'd2,
      S_ROUND = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [3:0] C_LAST_RK    = 4'd10;
   localparam logic [3:0] C_FIRST_ROUND = 4'd9;

   state_t        r_state;
   state_t        w_state_nxt;
   logic          w_key_take;
   logic          w_iv_take;
   logic          w_accept;
   logic          w_kexp_step;
   logic          w_round_step;
   logic          w_final;

   logic [3:0]    r_round;
   logic [127:0]  r_rk [0:10];
   logic [127:0]  r_blk;
   logic [127:0]  r_pt;
   logic [127:0]  w_chain;

   // ------------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Key_Load and IV_Load both mask in_ready, so a simultaneous in_valid is
   // never taken in the same cycle as either strobe.
   assign in_ready = (r_state == S_READY) & ~key_load & ~iv_load;

   always_comb begin
      w_state_nxt  = r_state;
      w_key_take   = 1'b0;
      w_iv_take    = 1'b0;
      w_accept     = 1'b0;
      w_kexp_step  = 1'b0;
      w_round_step = 1'b0;
      w_final      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_iv_take = iv_load;
            if (key_load) begin
               w_key_take  = 1'b1;
               w_state_nxt = S_KEXP;
            end
         end
         S_KEXP: begin
            w_kexp_step = 1'b1;
            if (r_round == C_LAST_RK) w_state_nxt = S_READY;
         end
         S_READY: begin
            w_iv_take = iv_load;
            if (key_load) begin
               w_key_take  = 1'b1;
               w_state_nxt = S_KEXP;
            end else if (in_valid && in_ready) begin
               w_accept    = 1'b1;
               w_state_nxt = S_ROUND;
            end
         end
         S_ROUND: begin
            if (r_round == 4'd0) begin
               w_final     = 1'b1;
               w_state_nxt = S_DONE;
            end else begin
               w_round_step = 1'b1;
            end
         end
         S_DONE: begin
            if (out_ready) w_state_nxt = S_READY;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Forward key expansion: rk[r_round] is derived from rk[r_round-1]
   // ------------------------------------------------------------------------
   logic [3:0]   w_prev_idx;
   logic [127:0] w_rk_prev;
   logic [31:0]  w_rot;
   logic [31:0]  w_sub;
   logic [7:0]   w_rcon;
   logic [31:0]  w_k0, w_k1, w_k2, w_k3;
   logic [127:0] w_rk_next;

   // Clamp keeps the read inside the file when r_round is 0 outside KEXP.
   assign w_prev_idx = (r_round == 4'd0) ? 4'd0 : r_round - 4'd1;
   assign w_rk_prev  = r_rk[w_prev_idx];
   assign w_rot      = {w_rk_prev[23:0], w_rk_prev[31:24]};

   for (genvar g = 0; g < 4; g++) begin : g_fwd_sbox
      aes_sbox u_sbox (.in_byte(w_rot[8*g +: 8]), .out_byte(w_sub[8*g +: 8]));
   end

   always_comb begin
      w_rcon = 8'h00;
      case (r_round)
         4'd1:    w_rcon = 8'h01;
         4'd2:    w_rcon = 8'h02;
         4'd3:    w_rcon = 8'h04;
         4'd4:    w_rcon = 8'h08;
         4'd5:    w_rcon = 8'h10;
         4'd6:    w_rcon = 8'h20;
         4'd7:    w_rcon = 8'h40;
         4'd8:    w_rcon = 8'h80;
         4'd9:    w_rcon = 8'h1b;
         4'd10:   w_rcon = 8'h36;
         default: w_rcon = 8'h00;
      endcase
   end

   assign w_k0      = w_rk_prev[127:96] ^ w_sub ^ {w_rcon, 24'h000000};
   assign w_k1      = w_rk_prev[95:64]  ^ w_k0;
   assign w_k2      = w_rk_prev[63:32]  ^ w_k1;
   assign w_k3      = w_rk_prev[31:0]   ^ w_k2;
   assign w_rk_next = {w_k0, w_k1, w_k2, w_k3};

   // ------------------------------------------------------------------------
   // Inverse round datapath
   // ------------------------------------------------------------------------
   logic [127:0] w_isb;
   logic [127:0] w_ark;
   logic [127:0] w_inv_mix;

   // InvShiftRows is pure wiring: output byte (row, col) is fed from input
   // byte (row, col-row mod 4) straight into its inverse S-box.
   for (genvar b = 0; b < 16; b++) begin : g_inv_sbox
      localparam int c_row = b % 4;
      localparam int c_col = b / 4;
      localparam int c_src = c_row + 4 * ((c_col - c_row + 4) % 4);
      aes_inv_sbox u_isbox (
         .in_byte (r_blk[127-8*c_src -: 8]),
         .out_byte(w_isb[127-8*b -: 8])
      );
   end

   assign w_ark = w_isb ^ r_rk[r_round];

   function automatic logic [7:0] xt(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[31-8*i -: 8];
         x2    = xt(a[i]);
         x4    = xt(x2);
         x8    = xt(x4);
         m9[i] = x8 ^ a[i];
         mb[i] = x8 ^ x2 ^ a[i];
         md[i] = x8 ^ x4 ^ a[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   always_comb begin
      w_inv_mix = '0;
      for (int c = 0; c < 4; c++) begin
         w_inv_mix[127-32*c -: 32] = inv_mix_col(w_ark[127-32*c -: 32]);
      end
   end

   // ------------------------------------------------------------------------
   // Key file, block state, round counter and output register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_round <= 4'd0;
         r_blk   <= '0;
         r_pt    <= '0;
         for (int i = 0; i < 11; i++) r_rk[i] <= '0;
      end else begin
         if (w_key_take) begin
            r_rk[0] <= key;
            r_round <= 4'd1;
         end else if (w_kexp_step) begin
            r_rk[r_round] <= w_rk_next;
            r_round       <= (r_round == C_LAST_RK) ? 4'd0 : r_round + 4'd1;
         end else if (w_accept) begin
            r_blk   <= cipher_text ^ r_rk[10];
            r_round <= C_FIRST_ROUND;
         end else if (w_round_step) begin
            r_blk   <= w_inv_mix;
            r_round <= r_round - 4'd1;
         end
         if (w_final) r_pt <= w_ark ^ w_chain;
      end
   end

   // ------------------------------------------------------------------------
   // Chaining value (present only in CBC builds)
   // ------------------------------------------------------------------------
   if (CBC_EN != 0) begin : g_cbc
      logic [127:0] r_chain;
      logic [127:0] r_ct_hold;

      // iv_take (IDLE/READY) and final (ROUND) can never coincide.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_chain   <= '0;
            r_ct_hold <= '0;
         end else begin
            if (w_accept) r_ct_hold <= cipher_text;
            if (w_final)        r_chain <= r_ct_hold;
            else if (w_iv_take) r_chain <= iv;
         end
      end

      assign w_chain = r_chain;
   end else begin : g_ecb
      logic w_unused_chain;
      assign w_unused_chain = ^{iv, w_iv_take};
      assign w_chain        = '0;
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign plain_text = r_pt;
   assign out_valid  = (r_state == S_DONE);
   assign key_ready  = (r_state == S_READY) | (r_state == S_ROUND) | (r_state == S_DONE);
   assign busy       = (r_state == S_KEXP)  | (r_state == S_ROUND) | (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_aes_cbc_decrypt_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_cbc_decrypt_iter
// Description : Self-checking bench for aes_cbc_decrypt_iter. A CBC build and
//               an ECB build share all inputs. Random blocks are produced by
//               encrypting random values with a forward AES model, so the
//               expected decryption result is known by construction.
// Revision    : 1.0  initial release
// ============================================================================
module tb_aes_cbc_decrypt_iter;

   localparam logic [127:0] C_KEY_A  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C_CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C_PT_C1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C_KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] C_IV_B   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C_CT_B1  = 128'h7649abac8119b246cee98e9b12e9197d;
   localparam logic [127:0] C_PT_B1  = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] C_CT_B2  = 128'h5086cb9b507219ee95db113a917678b2;
   localparam logic [127:0] C_PT_B2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

   logic         clk = 1'b0;
   logic         rst, key_load, iv_load, in_valid, out_ready;
   logic [127:0] key, iv, cipher_text;
   logic         cbc_key_ready, cbc_in_ready, cbc_out_valid, cbc_busy;
   logic         ecb_key_ready, ecb_in_ready, ecb_out_valid, ecb_busy;
   logic [127:0] cbc_plain, ecb_plain;

   int n_checks = 0;
   int n_pass   = 0;
   int edge_cnt = 0;
   int hs_edge  = 0;

   logic [7:0]   sb [256];
   logic [127:0] m_rk [11];
   logic [127:0] m_chain;

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   aes_cbc_decrypt_iter #(.CBC_EN(1)) u_dut_cbc (
      .clk(clk), .rst(rst), .key_load(key_load), .key(key), .key_ready(cbc_key_ready),
      .iv_load(iv_load), .iv(iv), .in_valid(in_valid), .in_ready(cbc_in_ready),
      .cipher_text(cipher_text), .out_valid(cbc_out_valid), .out_ready(out_ready),
      .plain_text(cbc_plain), .busy(cbc_busy)
   );

   aes_cbc_decrypt_iter #(.CBC_EN(0)) u_dut_ecb (
      .clk(clk), .rst(rst), .key_load(key_load), .key(key), .key_ready(ecb_key_ready),
      .iv_load(iv_load), .iv(iv), .in_valid(in_valid), .in_ready(ecb_in_ready),
      .cipher_text(cipher_text), .out_valid(ecb_out_valid), .out_ready(out_ready),
      .plain_text(ecb_plain), .busy(ecb_busy)
   );

   // ---------------------------------------------------------------- model
   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
   endfunction

   // p walks the powers of 3 while q walks the matching inverses (powers of
   // 1/3), so sb[p] = affine(1/p) for every non-zero p.
   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      repeat (255) begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'h0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
         sb[p] = x ^ 8'h63;
      end
      sb[0] = 8'h63;
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   task automatic model_key(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int j = 0; j < 11; j++) m_rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
   endtask

   function automatic logic [127:0] model_enc(input logic [127:0] pt);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] v;
      v = pt ^ m_rk[0];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) s[i] = sb[v[127-8*i -: 8]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
         if (rnd != 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
               s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
         end else begin
            s = t;
         end
         for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
         v = v ^ m_rk[rnd];
      end
      return v;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ---------------------------------------------------------------- helpers
   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_key(input string tag);
      int   lat;
      logic early;
      lat   = 0;
      early = 1'b0;
      while (!cbc_key_ready && lat < 30) begin
         early = early | cbc_in_ready | ~cbc_busy;
         tick();
         lat++;
      end
      check({tag, "_latency"}, 128'(lat), 128'd10);
      check({tag, "_inready_low"}, 128'(early), 128'd0);
   endtask

   task automatic load_key(input logic [127:0] k, input string tag);
      key      = k;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      model_key(k);
      wait_key(tag);
   endtask

   task automatic send_block(input logic [127:0] ct);
      int n;
      n = 0;
      while (!cbc_in_ready && n < 100) begin
         tick();
         n++;
      end
      check("in_ready_wait", 128'(cbc_in_ready), 128'd1);
      in_valid    = 1'b1;
      cipher_text = ct;
      tick();
      in_valid    = 1'b0;
      cipher_text = rand128();
   endtask

   task automatic run_block(input logic [127:0] ct, input logic [127:0] exp_cbc,
                            input logic [127:0] exp_ecb, input int stall,
                            input bit disturb, input bit gap_check);
      int lat;
      send_block(ct);
      if (gap_check) check("accept_after_handshake", 128'(edge_cnt - hs_edge), 128'd1);
      lat = 0;
      while (!cbc_out_valid && lat < 40) begin
         if (disturb && lat == 3) begin
            key      = rand128();
            iv       = rand128();
            key_load = 1'b1;
            iv_load  = 1'b1;
         end
         tick();
         key_load = 1'b0;
         iv_load  = 1'b0;
         lat++;
      end
      check("block_latency", 128'(lat), 128'd10);
      check("plain_cbc", cbc_plain, exp_cbc);
      check("plain_ecb", ecb_plain, exp_ecb);
      for (int i = 0; i < stall; i++) begin
         tick();
         check("stall_plain", cbc_plain, exp_cbc);
         check("stall_valid_inready", 128'({cbc_out_valid, cbc_in_ready}), 128'b10);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      hs_edge   = edge_cnt;
      check("handshake_valid_inready", 128'({cbc_out_valid, cbc_in_ready}), 128'b01);
      m_chain = ct;
   endtask

   task automatic run_random(input int stall, input bit disturb, input bit gap_check);
      logic [127:0] q;
      q = rand128();
      run_block(model_enc(q), q ^ m_chain, q, stall, disturb, gap_check);
   endtask

   // ---------------------------------------------------------------- watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      logic seen_valid, seen_ready;
      build_sbox();
      rst = 1'b1; key_load = 1'b0; iv_load = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      key = '0; iv = '0; cipher_text = '0; m_chain = '0;
      tick();
      tick();

      // Reset values
      check("rst_plain", cbc_plain, 128'd0);
      check("rst_flags", 128'({cbc_out_valid, cbc_key_ready, cbc_in_ready, cbc_busy}), 128'd0);
      rst = 1'b0;
      tick();
      check("idle_in_ready", 128'(cbc_in_ready), 128'd0);

      // FIPS-197 C.1 with key-expansion latency
      load_key(C_KEY_A, "kexp_a");
      run_block(C_CT_C1, C_PT_C1, C_PT_C1 ^ m_chain, 0, 1'b0, 1'b0);

      // SP800-38A F.2.2: IV load has priority over a pending block
      load_key(C_KEY_B, "kexp_b");
      iv          = C_IV_B;
      iv_load     = 1'b1;
      in_valid    = 1'b1;
      cipher_text = rand128();
      #1;
      check("iv_priority_in_ready", 128'(cbc_in_ready), 128'd0);
      tick();
      iv_load  = 1'b0;
      in_valid = 1'b0;
      check("iv_no_accept", 128'(cbc_busy), 128'd0);
      m_chain = C_IV_B;
      run_block(C_CT_B1, C_PT_B1, C_PT_B1 ^ m_chain, 0, 1'b0, 1'b0);
      run_block(C_CT_B2, C_PT_B2, C_PT_B2 ^ m_chain, 0, 1'b0, 1'b1);

      // Backpressure for 7 cycles, then the next block right after handshake
      run_random(7, 1'b0, 1'b0);
      run_random(0, 1'b0, 1'b1);

      // Random blocks with random gaps and stalls
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(0, 3)) tick();
         run_random(int'($urandom_range(0, 3)), 1'b0, 1'b0);
      end

      // Key_Load with In_Valid in READY: KEXP wins, no block taken
      key         = rand128();
      key_load    = 1'b1;
      in_valid    = 1'b1;
      cipher_text = rand128();
      #1;
      check("key_priority_in_ready", 128'(cbc_in_ready), 128'd0);
      tick();
      key_load = 1'b0;
      in_valid = 1'b0;
      check("key_priority_busy_keyready", 128'({cbc_busy, cbc_key_ready}), 128'b10);
      model_key(key);
      wait_key("kexp_prio");
      run_random(1, 1'b0, 1'b0);

      // Key_Load and IV_Load during ROUND are ignored
      run_random(0, 1'b1, 1'b0);
      run_random(0, 1'b0, 1'b0);

      // Reset asserted during round 5
      send_block(model_enc(rand128()));
      repeat (4) tick();
      rst = 1'b1;
      #1;
      check("midrst_plain", cbc_plain, 128'd0);
      check("midrst_flags", 128'({cbc_out_valid, cbc_key_ready, cbc_in_ready, cbc_busy,
                                  ecb_out_valid, ecb_key_ready}), 128'd0);
      tick();
      rst = 1'b0;
      m_chain = '0;
      seen_valid = 1'b0;
      seen_ready = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         seen_valid = seen_valid | cbc_out_valid | ecb_out_valid;
         seen_ready = seen_ready | cbc_key_ready | cbc_in_ready;
      end
      check("midrst_no_valid", 128'(seen_valid), 128'd0);
      check("midrst_no_ready", 128'(seen_ready), 128'd0);
      load_key(C_KEY_A, "kexp_after_rst");
      run_random(0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
